// File: rtl/wdt_rstctrl_pkg.sv
// Shared definitions for the watchdog reset sequencer: state encoding,
// CSR register offsets and the default software-reset key.
package wdt_rstctrl_pkg;

  localparam logic [1:0] ST_HOLD   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  localparam logic [4:0] R_CTRL  = 5'd0;
  localparam logic [4:0] R_STAT  = 5'd1;
  localparam logic [4:0] R_SWRST = 5'd2;

  localparam logic [7:0] SWRST_KEY_DEF = 8'h5a;

  // A programmed pulse length of zero still yields a one-tick reset pulse.
  function automatic logic [7:0] pulse_eff(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/wdt_reset_ctrl_ce_countdown.sv
// 8-bit loadable down-counter advanced by the ce tick; done flags the tick
// on which the count leaves 1, i.e. the last tick of the loaded window.
module ce_countdown #(
  parameter logic [7:0] INIT = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= INIT;
    else if (load)
      cnt <= load_val;
    else if (ce && cnt != 8'd0)
      cnt <= cnt - 8'd1;
  end

  assign done = ce && (cnt == 8'd1);

endmodule

// File: rtl/wdt_reset_ctrl.sv
// Watchdog reset sequencer: stretched SoC reset, settle window, boot-failure
// counting with sticky recovery select. WDT_RSTCTRL_SWRST_EN adds the SWRST register.
//   state  | meaning
//   HOLD   | soc_rst_out asserted, counting pulse_len ticks
//   SETTLE | reset released, counting SETTLE_LEN ticks
//   RUN    | SoC running, waiting for a bite or software request
module wdt_reset_ctrl
  import wdt_rstctrl_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR     = 5'h0,
  parameter logic [7:0] DEFAULT_PULSE = 8'd16,
  parameter logic [7:0] SETTLE_LEN    = 8'd4,
  parameter logic [2:0] FAIL_LIMIT    = 3'd3,
  parameter logic [7:0] SWRST_KEY     = SWRST_KEY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  input  logic       wdt_strobe,
  output logic       soc_rst_out,
  output logic       recovery_sel,
  output logic       irq
);

`ifdef WDT_RSTCTRL_SWRST_EN
  localparam bit SWRST_EN = 1'b1;
`else
  localparam bit SWRST_EN = 1'b0;
`endif

  localparam logic [4:0] A_CTRL  = BASE_ADDR + R_CTRL;
  localparam logic [4:0] A_STAT  = BASE_ADDR + R_STAT;
  localparam logic [4:0] A_SWRST = BASE_ADDR + R_SWRST;

  logic [1:0] state, state_nxt;
  logic [7:0] pulse_len;
  logic [2:0] fail_cnt, fail_nxt;
  logic       missed;
  logic       rec_nxt;
  logic       cnt_load, cnt_done;
  logic [7:0] cnt_val;
  logic       wr_stat, boot_ok, sw_req, start;

  assign wr_stat = csr_we && (csr_a == A_STAT);
  assign boot_ok = wr_stat && csr_di[0];
  assign sw_req  = SWRST_EN && csr_we && (csr_a == A_SWRST) && (csr_di == SWRST_KEY);
  assign start   = (state == ST_RUN) && (wdt_strobe || sw_req);

  ce_countdown #(.INIT(pulse_eff(DEFAULT_PULSE))) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD:   if (cnt_done) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt_done) state_nxt = ST_RUN;
      ST_RUN:    if (start)    state_nxt = ST_HOLD;
      default:                 state_nxt = ST_HOLD;
    endcase
  end

  // The counter is reloaded on the edge that enters HOLD or SETTLE.
  assign cnt_load = start || ((state == ST_HOLD) && cnt_done);
  assign cnt_val  = start ? pulse_eff(pulse_len) : SETTLE_LEN;

  always_comb begin
    fail_nxt = boot_ok ? 3'd0 : fail_cnt;
    if ((state == ST_RUN) && wdt_strobe && fail_nxt != 3'd7)
      fail_nxt = fail_nxt + 3'd1;
    rec_nxt = boot_ok ? 1'b0 : (recovery_sel || (fail_cnt >= FAIL_LIMIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_HOLD;
      soc_rst_out  <= 1'b1;
      pulse_len    <= DEFAULT_PULSE;
      fail_cnt     <= 3'd0;
      recovery_sel <= 1'b0;
      missed       <= 1'b0;
      irq          <= 1'b0;
    end else begin
      state        <= state_nxt;
      soc_rst_out  <= (state_nxt == ST_HOLD);
      fail_cnt     <= fail_nxt;
      recovery_sel <= rec_nxt;
      irq          <= rec_nxt && !recovery_sel;
      if (csr_we && csr_a == A_CTRL)
        pulse_len <= csr_di;
      if ((state != ST_RUN) && (wdt_strobe || sw_req))
        missed <= 1'b1;
      else if (wr_stat && csr_di[7])
        missed <= 1'b0;
    end
  end

  always_comb begin
    csr_do = 8'h00;
    if (csr_a == A_CTRL)
      csr_do = pulse_len;
    else if (csr_a == A_STAT)
      csr_do = {missed, recovery_sel, state, 1'b0, fail_cnt};
  end

endmodule

// File: doc/wdt_reset_ctrl.md
# wdt_reset_ctrl

Reset sequencer driven by the watchdog bite strobe. Each strobe asserts a stretched SoC reset pulse of programmable length in `ce` ticks, followed by a settle window. It counts consecutive failed boots and latches a recovery boot select once a limit is reached. Register access is through the shared 5-bit-address, 8-bit CSR bus, next to the watchdog.

## Interface
- `BASE_ADDR`, 5'h0: CSR base address.
- `DEFAULT_PULSE`, 8'd16: reset value of the pulse length register, in `ce` ticks.
- `SETTLE_LEN`, 8'd4: settle window after reset release, in `ce` ticks. Must be ≥1.
- `FAIL_LIMIT`, 3'd3: fail count at which `recovery_sel` latches. Must be ≥1.
- `SWRST_KEY`, 8'h5a: write value that requests a software reset.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `ce`, in, 1: tick enable, one cycle wide. Timing source for all tick counts.
- `csr_a`, in, 5: CSR address.
- `csr_di`, in, 8: CSR write data.
- `csr_we`, in, 1: CSR write strobe, one cycle.
- `csr_do`, out, 8: CSR read data. Combinational, 0 for unmapped addresses.
- `wdt_strobe`, in, 1: watchdog bite pulse, one cycle.
- `soc_rst_out`, out, 1: SoC reset, active-high, registered.
- `recovery_sel`, out, 1: recovery boot select, registered, sticky.
- `irq`, out, 1: one-cycle pulse on the rising edge of `recovery_sel`.

## Operation
- States: HOLD, SETTLE, RUN.
- HOLD
  - `soc_rst_out`=1.
  - Tick counter loads `pulse_len` on entry; a value of 0 is treated as 1.
  - Counter decrements on `ce`.
  - On the edge where `ce` is high and the counter is 1, go to SETTLE.
- SETTLE
  - `soc_rst_out`=0.
  - Counter loads `SETTLE_LEN` and counts down the same way.
  - At the end of the window, go to RUN.
- RUN
  - `wdt_strobe` → `fail_cnt` increments (saturating at 7), then go to HOLD.
  - A software reset request → go to HOLD without incrementing `fail_cnt`.
- A strobe or software request arriving in HOLD or SETTLE is ignored and sets the sticky `missed` flag.
- `recovery_sel` is set when `fail_cnt` ≥ `FAIL_LIMIT`. It is cleared only by `rst` or a boot-ok write.
- Registers:
  - `BASE_ADDR+0` CTRL (rw): `pulse_len`[7:0]. A new value takes effect at the next HOLD entry.
  - `BASE_ADDR+1` STAT
    - Read: {`missed`, `recovery_sel`, `state`[1:0], 1'b0, `fail_cnt`[2:0]}.
    - Write bit0=1: clears `fail_cnt` and `recovery_sel` (boot-ok).
    - Write bit7=1: clears `missed`.
  - `BASE_ADDR+2` SWRST (wo): writing `SWRST_KEY` requests a reset. Any other value has no effect. Reads return 0.
- Simultaneous events:
  - Boot-ok and `wdt_strobe` in the same cycle in RUN: clear first, then increment, giving `fail_cnt`=1.
  - Strobe and software request in the same cycle: treated as a strobe, so `fail_cnt` increments.
  - Boot-ok while `fail_cnt` ≥ `FAIL_LIMIT` clears `recovery_sel`. No `irq` is generated.

## Timing
- Reset values:
  - state=HOLD, counter=`DEFAULT_PULSE`, `soc_rst_out`=1 (the SoC is held in reset after power-up).
  - `pulse_len`=`DEFAULT_PULSE`, `fail_cnt`=0, `recovery_sel`=0, `missed`=0, `irq`=0.
- Strobe sampled at edge n in RUN: `soc_rst_out`=1 from n+1, `fail_cnt` is updated at n+1, and `recovery_sel`/`irq` are updated at n+2.
- HOLD lasts exactly `pulse_len` `ce` ticks. SETTLE lasts exactly `SETTLE_LEN` ticks.
- With `ce` held high, a pulse of N ticks is N cycles. With `ce` stuck low, HOLD persists.
- Asserting `rst` mid-sequence aborts immediately to the reset values.
- CSR writes take effect at the next edge.

## Configuration
- `WDT_RSTCTRL_SWRST_EN` defined: the SWRST register and software reset request exist.
- Undefined: `BASE_ADDR+2` is unmapped (reads 0, writes ignored), and only `wdt_strobe` starts a sequence.

## Structure
- Shared package `wdt_rstctrl_pkg` holds:
  - the state encoding (HOLD=2'd0, SETTLE=2'd1, RUN=2'd2);
  - register offsets `R_CTRL`/`R_STAT`/`R_SWRST`;
  - the default `SWRST_KEY`.
- One sub-module, `ce_countdown`: an 8-bit loadable down-counter gated by `ce` with a `done` output. It is shared between HOLD and SETTLE.

## Test plan
- Release `rst`, `ce` every cycle → `soc_rst_out` high for 16 cycles, then SETTLE for 4 cycles, then RUN; STAT reads 8'h20.
- Write CTRL=3, pulse `wdt_strobe` in RUN → `soc_rst_out` high for 3 `ce` ticks; `fail_cnt`=1.
- Three strobes, each issued in RUN → third gives `fail_cnt`=3, `recovery_sel`=1, single-cycle `irq`; write STAT=8'h01 → `fail_cnt`=0, `recovery_sel`=0.
- Strobe during HOLD → no extra pulse, `fail_cnt` unchanged, STAT bit7=1; write STAT=8'h80 clears it.
- With `WDT_RSTCTRL_SWRST_EN`: write SWRST=8'h5a → pulse, `fail_cnt` unchanged; write 8'h5b → no pulse. Without the macro, 8'h5a → no pulse.
- Boot-ok write and strobe in the same RUN cycle → `fail_cnt`=1; assert `rst` mid-HOLD → all outputs return to reset values in the same cycle.
